// File: rtl/episode_controller.sv
// Episode sequencer for the Q-learning gridworld: runs episodes, classifies outcomes, stops on streak or budget.
// Optional outcome counters are enabled by defining EPISODE_STATS_EN.
module episode_controller #(
    parameter int GRID_W         = 5,
    parameter int GRID_H         = 5,
    parameter int STATE_W        = 6,
    parameter int START_STATE    = 1,
    parameter int GOAL_STATE     = 25,
    parameter int MAX_STEPS      = 15,
    parameter int MAX_EPISODES   = 256,
    parameter int SUCCESS_STREAK = 4,
    localparam int N             = GRID_W * GRID_H,
    localparam int EP_W          = $clog2(MAX_EPISODES + 1)
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               run_i,
    input  logic [N-1:0]       hazard_map_i,
    input  logic               step_valid_i,
    input  logic [STATE_W-1:0] next_state_i,
    output logic [STATE_W-1:0] current_state_o,
    output logic               agent_start_o,
    output logic               agent_en_o,
    output logic               print_o,
    output logic [EP_W-1:0]    episode_o,
    output logic [7:0]         step_count_o,
    output logic               ep_end_o,
    output logic [1:0]         ep_result_o,
    output logic               finish_o,
    output logic               fail_o,
    output logic [EP_W-1:0]    goal_hits_o,
    output logic [EP_W-1:0]    hazard_hits_o,
    output logic [EP_W-1:0]    timeouts_o
);

    typedef enum logic [2:0] {IDLE, START, RUN, FINISH, FAIL} state_e;

    state_e             state_q, state_d;
    logic [STATE_W-1:0] curState_q, curState_d;
    logic [7:0]         stepCount_q, stepCount_d;
    logic [EP_W-1:0]    episode_q, episode_d;
    logic [3:0]         streak_q, streak_d;
    logic               epEnd_q, epEnd_d;
    logic [1:0]         epResult_q, epResult_d;
    logic               finish_q, finish_d;
    logic               fail_q, fail_d;

    logic isGoal, isHazard, isTimeout, mapHit;
    logic [3:0] streakNext;

    // Classify the presented next state; goal outranks hazard, which outranks timeout.
    always_comb begin
        mapHit = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (int'(next_state_i) == i + 1 && hazard_map_i[i]) begin
                mapHit = 1'b1;
            end
        end
        isGoal     = (next_state_i == STATE_W'(GOAL_STATE));
        isHazard   = (next_state_i == '0) || (int'(next_state_i) > N) || mapHit;
        isTimeout  = ((stepCount_q + 8'd1) == 8'(MAX_STEPS));
        streakNext = isGoal ? (streak_q + 4'd1) : 4'd0;
    end

    always_comb begin
        state_d       = state_q;
        curState_d    = curState_q;
        stepCount_d   = stepCount_q;
        episode_d     = episode_q;
        streak_d      = streak_q;
        epEnd_d       = 1'b0;
        epResult_d    = epResult_q;
        finish_d      = finish_q;
        fail_d        = fail_q;
        agent_start_o = 1'b0;
        agent_en_o    = 1'b0;
        print_o       = 1'b0;
        case (state_q)
            IDLE: begin
                if (run_i) begin
                    state_d = START;
                end
            end
            START: begin
                agent_start_o = 1'b1;
                agent_en_o    = 1'b1;
                print_o       = 1'b1;
                curState_d    = STATE_W'(START_STATE);
                stepCount_d   = 8'd0;
                episode_d     = episode_q + EP_W'(1);
                state_d       = RUN;
            end
            RUN: begin
                agent_en_o = run_i;
                print_o    = 1'b1;
                // A low run freezes the episode entirely, including pending steps.
                if (run_i && step_valid_i) begin
                    curState_d  = next_state_i;
                    stepCount_d = stepCount_q + 8'd1;
                    if (isGoal || isHazard || isTimeout) begin
                        epEnd_d    = 1'b1;
                        epResult_d = isGoal ? 2'b00 : (isHazard ? 2'b01 : 2'b10);
                        streak_d   = streakNext;
                        if (streakNext == 4'(SUCCESS_STREAK)) begin
                            state_d  = FINISH;
                            finish_d = 1'b1;
                        end else if (episode_q == EP_W'(MAX_EPISODES)) begin
                            state_d = FAIL;
                            fail_d  = 1'b1;
                        end else begin
                            state_d = START;
                        end
                    end
                end
            end
            FINISH, FAIL: begin
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            curState_q  <= STATE_W'(START_STATE);
            stepCount_q <= 8'd0;
            episode_q   <= '0;
            streak_q    <= 4'd0;
            epEnd_q     <= 1'b0;
            epResult_q  <= 2'b00;
            finish_q    <= 1'b0;
            fail_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            curState_q  <= curState_d;
            stepCount_q <= stepCount_d;
            episode_q   <= episode_d;
            streak_q    <= streak_d;
            epEnd_q     <= epEnd_d;
            epResult_q  <= epResult_d;
            finish_q    <= finish_d;
            fail_q      <= fail_d;
        end
    end

    assign current_state_o = curState_q;
    assign step_count_o    = stepCount_q;
    assign episode_o       = episode_q;
    assign ep_end_o        = epEnd_q;
    assign ep_result_o     = epResult_q;
    assign finish_o        = finish_q;
    assign fail_o          = fail_q;

`ifdef EPISODE_STATS_EN
    logic [EP_W-1:0] goalHits_q, hazardHits_q, timeouts_q;

    // Counters follow the registered ep_end pulse, so they lag it by one cycle and saturate.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            goalHits_q   <= '0;
            hazardHits_q <= '0;
            timeouts_q   <= '0;
        end else if (epEnd_q) begin
            case (epResult_q)
                2'b00: if (goalHits_q != '1) goalHits_q <= goalHits_q + EP_W'(1);
                2'b01: if (hazardHits_q != '1) hazardHits_q <= hazardHits_q + EP_W'(1);
                2'b10: if (timeouts_q != '1) timeouts_q <= timeouts_q + EP_W'(1);
                default: ;
            endcase
        end
    end

    assign goal_hits_o   = goalHits_q;
    assign hazard_hits_o = hazardHits_q;
    assign timeouts_o    = timeouts_q;
`else
    assign goal_hits_o   = '0;
    assign hazard_hits_o = '0;
    assign timeouts_o    = '0;
`endif

endmodule
